psw_flag_unit: RTL and testbench
================================

Name: psw_flag_unit

Overview:
- Produces and holds the Program Status Word. The branch/CEX condition evaluator reads this word and tests its flags.
- Generates the C, Z, N and V flags from the ALU operands and result, applying per-flag write masks.
- Handles whole-word PSW writes, the sleep bit, and priority save/restore on exception entry and return through a one-deep shadow register.
- Sits between the ALU and the control unit. Its output feeds the condition evaluator directly.

Parameters:
- WIDTH, 16, datapath width; byte mode uses bits 7:0.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op_a  in  WIDTH  ALU first operand (dst)
- op_b  in  WIDTH  ALU second operand (src)
- alu_res  in  WIDTH  ALU result
- alu_cout  in  1  ALU carry-out (ADD/SUB) or last bit shifted out (SHIFT)
- op_class  in  2  0=ADD, 1=SUB (a-b), 2=LOGIC, 3=SHIFT
- byte_mode  in  1  1 = evaluate on bits 7:0 only
- upd_en  in  1  flag-update strobe
- flag_mask  in  4  {V,N,Z,C}; 1 = that flag may change
- psw_wr  in  1  whole-word load strobe
- psw_wr_data  in  16  data for whole-word load
- sleep_set  in  1  set the SLP bit
- exc_enter  in  1  exception entry strobe
- exc_priority  in  3  new current priority on entry
- exc_return  in  1  exception return strobe
- psw_out  out  16  registered PSW
- shadow_valid  out  1  shadow register holds a saved PSW
- fault  out  1  one-cycle pulse on illegal nest or illegal return

Behaviour:
- PSW layout:
  - bit0 C, bit1 Z, bit2 N, bit3 SLP, bit4 V
  - bits 7:5 current priority
  - bits 15:13 previous priority
  - all other bits reserved: always read 0, ignored on write
- Reset (async, immediate): psw_out=0x0000, shadow=0x0000, shadow_valid=0, fault=0.
- All updates register on the rising clk edge. psw_out reflects an update one cycle after the strobe.
- Per-cycle priority: exc_enter > exc_return > psw_wr > (upd_en, sleep_set). Lower-priority strobes in the same cycle are discarded.
- upd_en and sleep_set may act together; they touch disjoint bits.
- Flag generation; msb = bit 7 if byte_mode, else bit WIDTH-1; r = alu_res masked to the active width:
  - Z = (r == 0)
  - N = r[msb]
  - ADD: C = alu_cout; V = (a[msb]==b[msb]) && (r[msb]!=a[msb])
  - SUB: C = alu_cout (1 = no borrow); V = (a[msb]!=b[msb]) && (r[msb]!=a[msb])
  - LOGIC: C and V held regardless of mask
  - SHIFT: C = alu_cout; V = 0
  - Only flags whose flag_mask bit is 1 change; masked flags hold. Other bits never change on upd_en.
- psw_wr: psw_out <= psw_wr_data with reserved bits forced to 0.
- sleep_set: SLP <= 1.
- exc_enter with shadow_valid=0:
  - shadow <= psw_out; shadow_valid <= 1
  - new PSW: bits 15:13 = old bits 7:5; bits 7:5 = exc_priority; SLP = 0; C/Z/N/V = 0
- exc_enter with shadow_valid=1: illegal nest. PSW and shadow are unchanged; fault=1 for one cycle.
- exc_return with shadow_valid=1: psw_out <= shadow; shadow_valid <= 0.
- exc_return with shadow_valid=0: PSW unchanged; fault=1 for one cycle.
- fault is registered, high exactly one cycle per offending strobe, and otherwise 0.
- Reset asserted mid-sequence (e.g. shadow_valid=1) clears everything. A subsequent exc_return faults.

Test Plan:
- Word ADD: a=0x7FFF, b=0x0001, res=0x8000, cout=0, mask=0xF, upd_en -> next cycle C=0 Z=0 N=1 V=1; psw_out=0x0014.
- Byte SUB: a=0x0080, b=0x0001, res=0x007F, cout=1, byte_mode=1, mask=0xF -> C=1 Z=0 N=0 V=1; psw_out=0x0011.
- Masked LOGIC: PSW=0x0011; res=0x0000, op_class=2, mask=0x2 -> only Z sets; psw_out=0x0013 (C and V held).
- Exception round trip: PSW=0x0068 (priority 3, SLP=1) -> exc_enter, prio 5 -> psw_out=0x60A0, shadow_valid=1 -> exc_return -> psw_out=0x0068, shadow_valid=0.
- Illegal strobes: exc_return with shadow_valid=0 -> fault pulse 1 cycle, PSW unchanged. Second exc_enter while shadow_valid=1 -> fault pulse, PSW and shadow unchanged.
- Priority and reset: exc_enter, psw_wr and upd_en asserted in the same cycle -> only the entry takes effect. rst asserted mid-cycle -> psw_out=0x0000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/psw_flag_unit.sv
// Program Status Word: ALU flag generation, whole-word load, sleep bit, and one-deep exception save/restore.
// Updates land one cycle after the strobe; there is no backpressure, and every strobe is accepted or faulted that cycle.
module psw_flag_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout,
  input  logic [1:0]       op_class,
  input  logic             byte_mode,
  input  logic             upd_en,
  input  logic [3:0]       flag_mask,
  input  logic             psw_wr,
  input  logic [15:0]      psw_wr_data,
  input  logic             sleep_set,
  input  logic             exc_enter,
  input  logic [2:0]       exc_priority,
  input  logic             exc_return,
  output logic [15:0]      psw_out,
  output logic             shadow_valid,
  output logic             fault
);

  localparam logic [15:0] PSW_IMPL = 16'hE0FF;

  localparam int C_BIT   = 0;
  localparam int Z_BIT   = 1;
  localparam int N_BIT   = 2;
  localparam int SLP_BIT = 3;
  localparam int V_BIT   = 4;

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_SUB   = 2'd1;
  localparam logic [1:0] OP_LOGIC = 2'd2;

  logic [15:0]      psw;
  logic [15:0]      shadow;
  logic [WIDTH-1:0] act_mask;
  logic [WIDTH-1:0] msb_sel;
  logic [WIDTH-1:0] res_m;
  logic             msb_a, msb_b, msb_r;
  logic             c_new, z_new, n_new, v_new;
  logic [15:0]      upd_word;
  logic [15:0]      enter_word;

  // Sign bits are picked with a one-hot select so the full operand words feed the logic.
  always_comb begin
    act_mask = byte_mode ? WIDTH'(8'hFF) : '1;
    msb_sel  = byte_mode ? WIDTH'(8'h80) : (WIDTH'(1) << (WIDTH - 1));
    res_m    = alu_res & act_mask;
    msb_a    = |(op_a & msb_sel);
    msb_b    = |(op_b & msb_sel);
    msb_r    = |(res_m & msb_sel);

    z_new = (res_m == '0);
    n_new = msb_r;
    c_new = psw[C_BIT];
    v_new = psw[V_BIT];
    case (op_class)
      OP_ADD: begin
        c_new = alu_cout;
        v_new = (msb_a == msb_b) && (msb_r != msb_a);
      end
      OP_SUB: begin
        c_new = alu_cout;
        v_new = (msb_a != msb_b) && (msb_r != msb_a);
      end
      OP_LOGIC: begin
        c_new = psw[C_BIT];
        v_new = psw[V_BIT];
      end
      default: begin
        c_new = alu_cout;
        v_new = 1'b0;
      end
    endcase

    upd_word = psw;
    if (upd_en) begin
      if (flag_mask[0]) upd_word[C_BIT] = c_new;
      if (flag_mask[1]) upd_word[Z_BIT] = z_new;
      if (flag_mask[2]) upd_word[N_BIT] = n_new;
      if (flag_mask[3]) upd_word[V_BIT] = v_new;
    end
    if (sleep_set) upd_word[SLP_BIT] = 1'b1;

    // Entry moves current priority to previous and clears flags and SLP.
    enter_word = {psw[7:5], 5'b0_0000, exc_priority, 5'b0_0000};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psw          <= 16'h0000;
      shadow       <= 16'h0000;
      shadow_valid <= 1'b0;
      fault        <= 1'b0;
    end else begin
      fault <= 1'b0;
      if (exc_enter) begin
        if (shadow_valid) begin
          fault <= 1'b1;
        end else begin
          shadow       <= psw;
          shadow_valid <= 1'b1;
          psw          <= enter_word;
        end
      end else if (exc_return) begin
        if (shadow_valid) begin
          psw          <= shadow;
          shadow_valid <= 1'b0;
        end else begin
          fault <= 1'b1;
        end
      end else if (psw_wr) begin
        psw <= psw_wr_data & PSW_IMPL;
      end else if (upd_en || sleep_set) begin
        psw <= upd_word;
      end
    end
  end

  assign psw_out = psw;

endmodule

// File: tb/tb_psw_flag_unit.sv
// Scoreboard bench for psw_flag_unit: stimulus pushes reference-model expectations, a monitor pops and compares each cycle.
module tb_psw_flag_unit;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [15:0] psw;
    logic        sv;
    logic        flt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] op_a = '0, op_b = '0, alu_res = '0;
  logic             alu_cout = 1'b0;
  logic [1:0]       op_class = 2'd0;
  logic             byte_mode = 1'b0;
  logic             upd_en = 1'b0;
  logic [3:0]       flag_mask = 4'h0;
  logic             psw_wr = 1'b0;
  logic [15:0]      psw_wr_data = 16'h0;
  logic             sleep_set = 1'b0;
  logic             exc_enter = 1'b0;
  logic [2:0]       exc_priority = 3'd0;
  logic             exc_return = 1'b0;
  logic [15:0]      psw_out;
  logic             shadow_valid;
  logic             fault;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  // Reference model state, kept as separate fields rather than a packed word.
  int m_c, m_z, m_n, m_v, m_slp, m_cur, m_prev;
  int m_shadow;
  int m_sv;
  int m_flt;

  psw_flag_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .alu_res(alu_res),
    .alu_cout(alu_cout), .op_class(op_class), .byte_mode(byte_mode),
    .upd_en(upd_en), .flag_mask(flag_mask), .psw_wr(psw_wr),
    .psw_wr_data(psw_wr_data), .sleep_set(sleep_set), .exc_enter(exc_enter),
    .exc_priority(exc_priority), .exc_return(exc_return),
    .psw_out(psw_out), .shadow_valid(shadow_valid), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic int model_word();
    return (m_prev * 8192) + (m_cur * 32) + (m_v * 16) + (m_slp * 8) + (m_n * 4) + (m_z * 2) + m_c;
  endfunction

  function automatic void model_load(input int w);
    m_c    = w % 2;
    m_z    = (w / 2) % 2;
    m_n    = (w / 4) % 2;
    m_slp  = (w / 8) % 2;
    m_v    = (w / 16) % 2;
    m_cur  = (w / 32) % 8;
    m_prev = (w / 8192) % 8;
  endfunction

  function automatic void model_reset();
    model_load(0);
    m_shadow = 0;
    m_sv     = 0;
    m_flt    = 0;
  endfunction

  // Apply the current drive values to the model and queue the expected post-edge outputs.
  task automatic issue();
    int w, top, r, sa, sb, sr, nc, nv, cv_ok;
    exp_t e;
    m_flt = 0;
    if (exc_enter) begin
      if (m_sv != 0) m_flt = 1;
      else begin
        m_shadow = model_word();
        m_sv = 1;
        m_prev = m_cur;
        m_cur = int'(exc_priority);
        m_slp = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
      end
    end else if (exc_return) begin
      if (m_sv != 0) begin
        model_load(m_shadow);
        m_sv = 0;
      end else m_flt = 1;
    end else if (psw_wr) begin
      model_load(int'(psw_wr_data));
    end else begin
      if (upd_en) begin
        w   = byte_mode ? 8 : WIDTH;
        top = 1 << (w - 1);
        r   = int'(alu_res) % (1 << w);
        sa  = ((int'(op_a) % (1 << w)) >= top) ? 1 : 0;
        sb  = ((int'(op_b) % (1 << w)) >= top) ? 1 : 0;
        sr  = (r >= top) ? 1 : 0;
        cv_ok = 1; nc = int'(alu_cout); nv = 0;
        case (op_class)
          2'd0: nv = (sa == sb && sr != sa) ? 1 : 0;
          2'd1: nv = (sa != sb && sr != sa) ? 1 : 0;
          2'd2: cv_ok = 0;
          default: nv = 0;
        endcase
        if (flag_mask[0] && cv_ok != 0) m_c = nc;
        if (flag_mask[1]) m_z = (r == 0) ? 1 : 0;
        if (flag_mask[2]) m_n = sr;
        if (flag_mask[3] && cv_ok != 0) m_v = nv;
      end
      if (sleep_set) m_slp = 1;
    end
    e.psw = 16'(model_word());
    e.sv  = (m_sv != 0);
    e.flt = (m_flt != 0);
    exp_q.push_back(e);
  endtask

  task automatic clear_strobes();
    upd_en = 1'b0; psw_wr = 1'b0; sleep_set = 1'b0;
    exc_enter = 1'b0; exc_return = 1'b0;
  endtask

  task automatic alu_step(input logic [1:0] cls, input logic bm, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] res, input logic co,
                          input logic [3:0] msk);
    @(negedge clk);
    clear_strobes();
    op_class = cls; byte_mode = bm; op_a = a; op_b = b; alu_res = res;
    alu_cout = co; flag_mask = msk; upd_en = 1'b1;
    issue();
  endtask

  task automatic ctl_step(input logic ent, input logic ret, input logic wr,
                          input logic [15:0] wdat, input logic [2:0] pri, input logic upd);
    @(negedge clk);
    clear_strobes();
    exc_enter = ent; exc_return = ret; psw_wr = wr; psw_wr_data = wdat;
    exc_priority = pri; upd_en = upd;
    if (upd) begin
      op_class = 2'd0; byte_mode = 1'b0; op_a = 16'h0001; op_b = 16'h0001;
      alu_res = 16'h0002; alu_cout = 1'b1; flag_mask = 4'hF;
    end
    issue();
  endtask

  task automatic idle_step();
    @(negedge clk);
    clear_strobes();
    issue();
  endtask

  task automatic check_now(input string name, input exp_t want);
    n_cmp++;
    if (psw_out !== want.psw || shadow_valid !== want.sv || fault !== want.flt) begin
      n_bad++;
      $display("FAIL %s: got psw=%04h sv=%0b fault=%0b, expected psw=%04h sv=%0b fault=%0b",
               name, psw_out, shadow_valid, fault, want.psw, want.sv, want.flt);
    end
  endtask

  task automatic rand_step();
    int pick, w;
    logic [16:0] sum;
    @(negedge clk);
    clear_strobes();
    op_class = 2'($urandom_range(0, 3));
    byte_mode = 1'($urandom_range(0, 1));
    op_a = 16'($urandom); op_b = 16'($urandom);
    w = byte_mode ? 8 : 16;
    case (op_class)
      2'd0: begin
        sum = byte_mode ? 17'({9'b0, op_a[7:0]} + {9'b0, op_b[7:0]}) : ({1'b0, op_a} + {1'b0, op_b});
        alu_res = op_a + op_b;
        alu_cout = byte_mode ? sum[8] : sum[16];
      end
      2'd1: begin
        alu_res = op_a - op_b;
        alu_cout = byte_mode ? (op_a[7:0] >= op_b[7:0]) : (op_a >= op_b);
      end
      2'd2: begin
        alu_res = $urandom_range(0, 1) ? (op_a & op_b) : (op_a ^ op_b);
        alu_cout = 1'($urandom_range(0, 1));
      end
      default: begin
        alu_res = op_a << 1;
        alu_cout = op_a[w-1];
      end
    endcase
    if ($urandom_range(0, 9) == 0) alu_res = 16'($urandom_range(0, 3) * 16'h0100);
    flag_mask = 4'($urandom);
    exc_priority = 3'($urandom);
    psw_wr_data = 16'($urandom);
    pick = $urandom_range(0, 99);
    exc_enter  = (pick < 8);
    exc_return = ($urandom_range(0, 99) < 10);
    psw_wr     = ($urandom_range(0, 99) < 8);
    upd_en     = ($urandom_range(0, 99) < 70);
    sleep_set  = ($urandom_range(0, 99) < 15);
    issue();
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now("scoreboard", e);
      end
    end
  end

  initial begin
    exp_t z;
    int guard;
    z = '0;
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_now("reset_state", z);
    rst = 1'b0;

    alu_step(2'd0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 4'hF);  // 0x0014
    alu_step(2'd1, 1'b1, 16'h0080, 16'h0001, 16'h007F, 1'b1, 4'hF);  // 0x0011
    alu_step(2'd2, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4'h2);  // 0x0013
    ctl_step(1'b0, 1'b0, 1'b1, 16'hFFFF, 3'd0, 1'b0);                // reserved bits drop
    ctl_step(1'b0, 1'b0, 1'b1, 16'h0068, 3'd0, 1'b0);
    ctl_step(1'b1, 1'b0, 1'b0, 16'h0000, 3'd5, 1'b0);                // 0x60A0
    ctl_step(1'b1, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b0);                // illegal nest
    idle_step();
    ctl_step(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);                // back to 0x0068
    ctl_step(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);                // illegal return
    idle_step();
    ctl_step(1'b1, 1'b0, 1'b1, 16'h1234, 3'd7, 1'b1);                // entry wins
    ctl_step(1'b0, 1'b0, 1'b1, 16'h00FF, 3'd0, 1'b1);                // write beats update

    // Asynchronous reset while an exception is active.
    ctl_step(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    ctl_step(1'b1, 1'b0, 1'b0, 16'h0000, 3'd4, 1'b0);
    @(negedge clk);
    clear_strobes();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_now("async_reset", z);
    @(negedge clk);
    rst = 1'b0;
    ctl_step(1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);                // faults after reset
    idle_step();

    for (int i = 0; i < 3000; i++) rand_step();

    @(negedge clk);
    clear_strobes();
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
